// File: rtl/mips_pkg.sv
// Shared MIPS ID-stage definitions: opcode/funct/REGIMM encodings, sequencer
// state encoding and the control-class decoder.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPND,
    REDIRECT,
    DSLOT
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_COND,
    CLS_JUMP,
    CLS_REG
  } ctrl_class_t;

  typedef struct packed {
    ctrl_class_t cls;
    logic        link;
    logic        link_rd;
  } ctrl_info_t;

  // link_rd marks JALR, whose link destination comes from the rd field
  function automatic ctrl_info_t decode_ctrl(input logic [5:0] opcode,
                                             input logic [4:0] rt,
                                             input logic [5:0] funct);
    ctrl_info_t info;
    info = '{cls: CLS_NONE, link: 1'b0, link_rd: 1'b0};
    case (opcode)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: info.cls = CLS_COND;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: info.cls = CLS_COND;
          RT_BLTZAL, RT_BGEZAL: begin
            info.cls  = CLS_COND;
            info.link = 1'b1;
          end
          default: info.cls = CLS_NONE;
        endcase
      end
      OP_J: info.cls = CLS_JUMP;
      OP_JAL: begin
        info.cls  = CLS_JUMP;
        info.link = 1'b1;
      end
      OP_SPECIAL: begin
        case (funct)
          FN_JR: info.cls = CLS_REG;
          FN_JALR: begin
            info.cls     = CLS_REG;
            info.link    = 1'b1;
            info.link_rd = 1'b1;
          end
          default: info.cls = CLS_NONE;
        endcase
      end
      default: info.cls = CLS_NONE;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target generation for branch, jump and register-indirect
// control transfers, plus the return address written on link.
module branch_target_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     instr_index,
  input  logic [XLEN-1:0] rs_value,
  output logic [XLEN-1:0] branch_target_c,
  output logic [XLEN-1:0] jump_target_c,
  output logic [XLEN-1:0] reg_target_c,
  output logic [XLEN-1:0] link_addr_c
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_offset;

  always_comb begin
    pc4             = pc + XLEN'(4);
    br_offset       = {{(XLEN-18){instr_index[15]}}, instr_index[15:0], 2'b00};
    branch_target_c = pc4 + br_offset;
    jump_target_c   = {pc4[XLEN-1:XLEN-4], instr_index, 2'b00};
    reg_target_c    = rs_value;
    link_addr_c     = pc + XLEN'(8);
  end

endmodule

// File: rtl/branch_sequencer.sv
// ID-stage control-flow sequencer: resolves branches/jumps, issues a one-shot
// PC redirect, tracks the delay slot, drives link writes and branch statistics.
module branch_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [4:0]  LINK_REG  = 5'd31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_instr,
  input  logic [XLEN-1:0]      id_pc,
  input  logic                 operand_ready,
  input  logic                 cond_taken,
  input  logic [XLEN-1:0]      rs_value,
  input  logic                 stall_ext,
  output logic                 pc_load,
  output logic [XLEN-1:0]      target_pc,
  output logic                 id_hold,
  output logic                 link_we,
  output logic [4:0]           link_reg,
  output logic [XLEN-1:0]      link_addr,
  output logic                 ds_pending,
  output logic                 ds_violation,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  seq_state_t      state;
  ctrl_info_t      info;
  logic            is_ctrl;
  logic            need_opnd;
  logic            taken;
  logic            resolve;
  logic [XLEN-1:0] resolved_target;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] reg_target;
  logic [XLEN-1:0] link_addr_nxt;

  branch_target_calc u_target (
    .pc              (id_pc),
    .instr_index     (id_instr[25:0]),
    .rs_value        (rs_value),
    .branch_target_c (branch_target),
    .jump_target_c   (jump_target),
    .reg_target_c    (reg_target),
    .link_addr_c     (link_addr_nxt)
  );

  // Classify the ID instruction and decide whether it resolves this cycle
  always_comb begin
    info            = decode_ctrl(id_instr[31:26], id_instr[20:16], id_instr[5:0]);
    is_ctrl         = id_valid && (info.cls != CLS_NONE);
    need_opnd       = (info.cls == CLS_COND) || (info.cls == CLS_REG);
    taken           = (info.cls == CLS_COND) ? cond_taken : 1'b1;
    resolve         = 1'b0;
    resolved_target = branch_target;
    case (info.cls)
      CLS_JUMP: resolved_target = jump_target;
      CLS_REG:  resolved_target = reg_target;
      default:  resolved_target = branch_target;
    endcase
    if (state == IDLE) begin
      resolve = is_ctrl && (!need_opnd || operand_ready);
    end else if (state == WAIT_OPND) begin
      resolve = is_ctrl && operand_ready;
    end
  end

  // An external stall freezes everything, including pulses already in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc_load      <= 1'b0;
      target_pc    <= '0;
      id_hold      <= 1'b0;
      link_we      <= 1'b0;
      link_reg     <= '0;
      link_addr    <= '0;
      ds_pending   <= 1'b0;
      ds_violation <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else if (!stall_ext) begin
      pc_load <= 1'b0;
      link_we <= 1'b0;
      if (resolve) begin
        target_pc  <= resolved_target;
        link_addr  <= link_addr_nxt;
        id_hold    <= 1'b0;
        ds_pending <= 1'b1;
        if (taken) begin
          state   <= REDIRECT;
          pc_load <= 1'b1;
        end else begin
          state <= DSLOT;
        end
        if (info.cls == CLS_COND) begin
          if (branch_count != CNT_MAX) branch_count <= branch_count + CNT_WIDTH'(1);
          if (taken && (taken_count != CNT_MAX)) taken_count <= taken_count + CNT_WIDTH'(1);
        end
        // AL branches write the return address whether or not they are taken
        if (info.link) begin
          link_we  <= 1'b1;
          link_reg <= info.link_rd ? id_instr[15:11] : LINK_REG;
        end
      end else begin
        case (state)
          IDLE: begin
            if (is_ctrl) begin
              state   <= WAIT_OPND;
              id_hold <= 1'b1;
            end
          end
          WAIT_OPND: begin
            if (!is_ctrl) begin
              state   <= IDLE;
              id_hold <= 1'b0;
            end
          end
          REDIRECT: state <= DSLOT;
          DSLOT: begin
            if (is_ctrl) ds_violation <= 1'b1;
            if (id_valid) begin
              state      <= IDLE;
              ds_pending <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized and directed checks of branch_sequencer against a transaction-level
// model of redirect, link, delay-slot and statistics behaviour.
module tb_branch_sequencer;

  localparam int unsigned CW   = 8;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] NOP  = 32'h0000_0021;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic          operand_ready;
  logic          cond_taken;
  logic [31:0]   rs_value;
  logic          stall_ext;
  logic          pc_load;
  logic [31:0]   target_pc;
  logic          id_hold;
  logic          link_we;
  logic [4:0]    link_reg;
  logic [31:0]   link_addr;
  logic          ds_pending;
  logic          ds_violation;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] taken_count;

  int vectors     = 0;
  int miscompares = 0;
  int bc          = 0;
  int tc          = 0;

  always #5 clk = ~clk;

  branch_sequencer #(.CNT_WIDTH(CW), .LINK_REG(5'd31)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .operand_ready (operand_ready),
    .cond_taken    (cond_taken),
    .rs_value      (rs_value),
    .stall_ext     (stall_ext),
    .pc_load       (pc_load),
    .target_pc     (target_pc),
    .id_hold       (id_hold),
    .link_we       (link_we),
    .link_reg      (link_reg),
    .link_addr     (link_addr),
    .ds_pending    (ds_pending),
    .ds_violation  (ds_violation),
    .branch_count  (branch_count),
    .taken_count   (taken_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // Saturating statistics model
  task automatic model_count(input logic is_cond, input logic tk);
    if (is_cond) begin
      if (bc < CMAX) bc++;
      if (tk && tc < CMAX) tc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    vectors++;
    if ({pc_load, target_pc, id_hold, link_we, link_reg, link_addr, ds_pending, ds_violation,
         branch_count, taken_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got pc_load=%b tgt=%h hold=%b lwe=%b ds=%b viol=%b bc=%0d tc=%0d, expected all zero",
               pc_load, target_pc, id_hold, link_we, ds_pending, ds_violation, branch_count, taken_count);
    end
    reset = 1'b0;
    bc = 0;
    tc = 0;
  endtask

  task automatic test_beq_taken;
    id_valid = 1'b1; id_instr = i_type(6'h04, 5'd2, 16'h0004); id_pc = 32'h0040_0010;
    operand_ready = 1'b1; cond_taken = 1'b1;
    tick;
    model_count(1'b1, 1'b1);
    vectors++;
    if ({pc_load, id_hold, ds_pending} !== 3'b101) begin
      miscompares++;
      $display("FAIL beq_flags: got pc_load/hold/ds=%b expected 101", {pc_load, id_hold, ds_pending});
    end
    vectors++;
    if (target_pc !== 32'h0040_0024) begin
      miscompares++;
      $display("FAIL beq_target: got %h expected 00400024", target_pc);
    end
    vectors++;
    if ({branch_count, taken_count} !== {CW'(bc), CW'(tc)}) begin
      miscompares++;
      $display("FAIL beq_counters: got bc=%0d tc=%0d expected bc=%0d tc=%0d", branch_count, taken_count, bc, tc);
    end
    id_instr = NOP;
    tick;
    vectors++;
    if ({pc_load, ds_pending} !== 2'b01) begin
      miscompares++;
      $display("FAIL beq_oneshot: got pc_load/ds=%b expected 01", {pc_load, ds_pending});
    end
    tick;
    vectors++;
    if ({pc_load, ds_pending} !== 2'b00) begin
      miscompares++;
      $display("FAIL beq_ds_exit: got pc_load/ds=%b expected 00", {pc_load, ds_pending});
    end
  endtask

  task automatic test_bne_not_taken;
    id_valid = 1'b1; id_instr = i_type(6'h05, 5'd2, 16'h0010); id_pc = 32'h0040_0040;
    operand_ready = 1'b1; cond_taken = 1'b0;
    tick;
    model_count(1'b1, 1'b0);
    vectors++;
    if ({pc_load, id_hold, ds_pending} !== 3'b001) begin
      miscompares++;
      $display("FAIL bne_flags: got pc_load/hold/ds=%b expected 001", {pc_load, id_hold, ds_pending});
    end
    vectors++;
    if ({branch_count, taken_count} !== {CW'(bc), CW'(tc)}) begin
      miscompares++;
      $display("FAIL bne_counters: got bc=%0d tc=%0d expected bc=%0d tc=%0d", branch_count, taken_count, bc, tc);
    end
    id_instr = NOP;
    tick;
    vectors++;
    if ({pc_load, ds_pending} !== 2'b00) begin
      miscompares++;
      $display("FAIL bne_ds_exit: got pc_load/ds=%b expected 00", {pc_load, ds_pending});
    end
  endtask

  task automatic test_jal;
    id_valid = 1'b1; id_instr = {6'h03, 26'h010_0040}; id_pc = 32'h0040_0000;
    operand_ready = 1'b0; cond_taken = 1'b0;
    tick;
    vectors++;
    if ({pc_load, target_pc} !== {1'b1, 32'h0040_0100}) begin
      miscompares++;
      $display("FAIL jal_redirect: got pc_load=%b tgt=%h expected 1 00400100", pc_load, target_pc);
    end
    vectors++;
    if ({link_we, link_reg, link_addr} !== {1'b1, 5'd31, 32'h0040_0008}) begin
      miscompares++;
      $display("FAIL jal_link: got we=%b reg=%0d addr=%h expected 1 31 00400008", link_we, link_reg, link_addr);
    end
    id_instr = NOP;
    tick;
    vectors++;
    if ({pc_load, link_we} !== 2'b00) begin
      miscompares++;
      $display("FAIL jal_pulse: got pc_load/link_we=%b expected 00", {pc_load, link_we});
    end
    tick;
  endtask

  task automatic test_jr_wait;
    id_valid = 1'b1; id_instr = {6'h00, 5'd4, 15'h0, 6'h08}; id_pc = 32'h0040_0080;
    rs_value = 32'h0040_0200; operand_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if ({pc_load, id_hold} !== 2'b01) begin
        miscompares++;
        $display("FAIL jr_wait[%0d]: got pc_load/hold=%b expected 01", i, {pc_load, id_hold});
      end
    end
    operand_ready = 1'b1;
    tick;
    vectors++;
    if ({pc_load, id_hold, target_pc} !== {2'b10, 32'h0040_0200}) begin
      miscompares++;
      $display("FAIL jr_redirect: got pc_load/hold=%b tgt=%h expected 10 00400200", {pc_load, id_hold}, target_pc);
    end
    id_instr = NOP;
    tick;
    tick;
  endtask

  task automatic test_stall_dslot;
    id_valid = 1'b1; id_instr = {6'h01, 5'd3, 5'h11, 16'hFFFC}; id_pc = 32'h0040_0100;
    operand_ready = 1'b1; cond_taken = 1'b1;
    tick;
    model_count(1'b1, 1'b1);
    stall_ext = 1'b1; id_instr = NOP;
    for (int i = 0; i < 2; i++) begin
      tick;
      vectors++;
      if ({pc_load, link_we, ds_pending, link_reg, target_pc} !== {3'b111, 5'd31, 32'h0040_00F4}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got pc_load/lwe/ds=%b reg=%0d tgt=%h expected 111 31 004000f4",
                 i, {pc_load, link_we, ds_pending}, link_reg, target_pc);
      end
    end
    stall_ext = 1'b0; id_instr = i_type(6'h04, 5'd2, 16'h0008);
    tick;
    vectors++;
    if ({pc_load, link_we, ds_pending} !== 3'b001) begin
      miscompares++;
      $display("FAIL stall_release: got pc_load/lwe/ds=%b expected 001", {pc_load, link_we, ds_pending});
    end
    tick;
    vectors++;
    if ({ds_violation, ds_pending} !== 2'b10) begin
      miscompares++;
      $display("FAIL ds_violation: got viol/ds=%b expected 10", {ds_violation, ds_pending});
    end
    id_instr = NOP;
    tick;
    vectors++;
    if ({pc_load, ds_violation, branch_count, taken_count} !== {2'b01, CW'(bc), CW'(tc)}) begin
      miscompares++;
      $display("FAIL ds_unresolved: got pc_load=%b viol=%b bc=%0d tc=%0d expected 0 1 %0d %0d",
               pc_load, ds_violation, branch_count, taken_count, bc, tc);
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] ins, pc, exp_tgt;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [4:0]  rsf, rd, lreg;
    logic        need, tk, lnk, cnd, is_cond;
    int          sel, k, off;
    for (int t = 0; t < n; t++) begin
      sel = $urandom_range(0, 11);
      pc  = $urandom() & 32'hFFFF_FFFC;
      imm = 16'($urandom());
      idx = 26'($urandom());
      rsf = 5'($urandom());
      rd  = 5'($urandom_range(1, 31));
      cnd = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, 3);
      rs_value = $urandom();
      off = int'($signed(imm)) * 4;
      lnk = 1'b0; lreg = 5'd31; need = 1'b1; is_cond = 1'b1;
      exp_tgt = pc + 32'd4 + 32'(off);
      ins = NOP;
      case (sel)
        0: ins = i_type(6'h04, rsf, imm);
        1: ins = i_type(6'h05, rsf, imm);
        2: ins = i_type(6'h06, 5'd0, imm);
        3: ins = i_type(6'h07, 5'd0, imm);
        4: ins = i_type(6'h01, 5'h00, imm);
        5: ins = i_type(6'h01, 5'h01, imm);
        6: begin ins = i_type(6'h01, 5'h10, imm); lnk = 1'b1; end
        7: begin ins = i_type(6'h01, 5'h11, imm); lnk = 1'b1; end
        8, 9: begin
          ins = {(sel == 8) ? 6'h02 : 6'h03, idx};
          lnk = (sel == 9); need = 1'b0; is_cond = 1'b0;
          exp_tgt = ((pc + 32'd4) & 32'hF000_0000) | ({6'b0, idx} << 2);
        end
        10: begin ins = {6'h00, rsf, 15'h0, 6'h08}; is_cond = 1'b0; exp_tgt = rs_value; end
        default: begin
          ins = {6'h00, rsf, 5'd0, rd, 5'd0, 6'h09};
          is_cond = 1'b0; lnk = 1'b1; lreg = rd; exp_tgt = rs_value;
        end
      endcase
      tk = is_cond ? cnd : 1'b1;
      id_valid = 1'b1; id_instr = ins; id_pc = pc; cond_taken = cnd;
      if (need) begin
        operand_ready = 1'b0;
        for (int i = 0; i < k; i++) begin
          tick;
          vectors++;
          if ({pc_load, id_hold} !== 2'b01) begin
            miscompares++;
            $display("FAIL rand[%0d] wait: got pc_load/hold=%b expected 01", t, {pc_load, id_hold});
          end
        end
        operand_ready = 1'b1;
      end else begin
        operand_ready = 1'($urandom_range(0, 1));
      end
      tick;
      model_count(is_cond, tk);
      vectors++;
      if ({pc_load, id_hold, link_we, ds_pending, target_pc} !== {tk, 1'b0, lnk, 1'b1, exp_tgt}) begin
        miscompares++;
        $display("FAIL rand[%0d] resolve ins=%h pc=%h: got pc_load/hold/lwe/ds=%b tgt=%h expected %b %h", t, ins, pc,
                 {pc_load, id_hold, link_we, ds_pending}, target_pc, {tk, 1'b0, lnk, 1'b1}, exp_tgt);
      end
      if (lnk) begin
        vectors++;
        if ({link_reg, link_addr} !== {lreg, pc + 32'd8}) begin
          miscompares++;
          $display("FAIL rand[%0d] link: got reg=%0d addr=%h expected %0d %h", t, link_reg, link_addr, lreg, pc + 32'd8);
        end
      end
      vectors++;
      if ({branch_count, taken_count} !== {CW'(bc), CW'(tc)}) begin
        miscompares++;
        $display("FAIL rand[%0d] counters: got bc=%0d tc=%0d expected bc=%0d tc=%0d", t, branch_count, taken_count, bc, tc);
      end
      id_instr = NOP; operand_ready = 1'($urandom_range(0, 1));
      if (tk) begin
        tick;
        vectors++;
        if ({pc_load, link_we, ds_pending, id_hold} !== 4'b0010) begin
          miscompares++;
          $display("FAIL rand[%0d] redirect_end: got pc_load/lwe/ds/hold=%b expected 0010", t,
                   {pc_load, link_we, ds_pending, id_hold});
        end
      end
      tick;
      vectors++;
      if ({pc_load, link_we, ds_pending, id_hold} !== 4'b0000) begin
        miscompares++;
        $display("FAIL rand[%0d] ds_exit: got pc_load/lwe/ds/hold=%b expected 0000", t,
                 {pc_load, link_we, ds_pending, id_hold});
      end
    end
  endtask

  task automatic test_saturation;
    id_valid = 1'b1; operand_ready = 1'b1; cond_taken = 1'b1; id_pc = 32'h0040_1000;
    for (int i = 0; i < CMAX + 3; i++) begin
      id_instr = i_type(6'h04, 5'd2, 16'h0001);
      tick;
      model_count(1'b1, 1'b1);
      id_instr = NOP;
      tick;
      tick;
    end
    vectors++;
    if ({branch_count, taken_count} !== {CW'(bc), CW'(tc)}) begin
      miscompares++;
      $display("FAIL sat_preload: got bc=%0d tc=%0d expected bc=%0d tc=%0d", branch_count, taken_count, bc, tc);
    end
    id_instr = i_type(6'h04, 5'd2, 16'h0001);
    tick;
    vectors++;
    if ({pc_load, branch_count, taken_count} !== {1'b1, {CW{1'b1}}, {CW{1'b1}}}) begin
      miscompares++;
      $display("FAIL sat_next: got pc_load=%b bc=%0d tc=%0d expected 1 %0d %0d", pc_load, branch_count, taken_count, CMAX, CMAX);
    end
    id_instr = NOP;
    tick;
    tick;
  endtask

  task automatic test_reset_in_wait;
    id_valid = 1'b1; id_instr = i_type(6'h04, 5'd2, 16'h0020); id_pc = 32'h0040_2000;
    operand_ready = 1'b0; cond_taken = 1'b1;
    tick;
    vectors++;
    if (id_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wait_entry: got hold=%b expected 1", id_hold);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0; id_valid = 1'b0; operand_ready = 1'b1;
    bc = 0; tc = 0;
    vectors++;
    if ({pc_load, target_pc, id_hold, link_we, link_reg, link_addr, ds_pending, ds_violation,
         branch_count, taken_count} !== '0) begin
      miscompares++;
      $display("FAIL rst_wait_state: got pc_load=%b hold=%b ds=%b viol=%b bc=%0d tc=%0d expected all zero",
               pc_load, id_hold, ds_pending, ds_violation, branch_count, taken_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if ({pc_load, id_hold, ds_pending} !== 3'b000) begin
        miscompares++;
        $display("FAIL rst_wait_quiet[%0d]: got pc_load/hold/ds=%b expected 000", i, {pc_load, id_hold, ds_pending});
      end
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_instr = NOP; id_pc = '0; operand_ready = 1'b0;
    cond_taken = 1'b0; rs_value = '0; stall_ext = 1'b0;
    test_reset;
    test_beq_taken;
    test_bne_not_taken;
    test_jal;
    test_jr_wait;
    test_stall_dslot;
    test_random(200);
    test_saturation;
    test_reset_in_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
